// File: rtl/spi_txn_controller.sv
// Transaction sequencer for the SPI memory slave: address byte, then one data byte or a
// burst of data bytes, driving shift-register, address-latch, memory and MISO enables.
module spi_txn_controller #(
  parameter int unsigned DATA_W   = 8,
  parameter bit          BURST_EN = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic cs_n,
  input  logic sclk_rise,
  input  logic sr_bit0,
  output logic sr_we,
  output logic addr_we,
  output logic addr_inc,
  output logic dm_we,
  output logic miso_buf,
  output logic busy,
  output logic abort
);

  localparam int unsigned     CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GOT_ADDR,
    S_READ_WAIT,
    S_READ_LOAD,
    S_READ_SHIFT,
    S_WRITE_RECV,
    S_WRITE_COMMIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] w_bit_cnt_next;
  logic             r_rd;
  logic             w_rd_next;
  logic             w_cnt_en;
  logic             w_last_bit;
  logic             w_abort;

  assign w_last_bit = sclk_rise && (r_bit_cnt == LAST_BIT);

  // Next-state decode; a raised chip select pre-empts every other transition.
  always_comb begin
    w_next    = r_state;
    w_rd_next = r_rd;
    w_cnt_en  = 1'b0;
    w_abort   = 1'b0;

    if ((r_state != S_IDLE) && cs_n) begin
      w_next  = S_IDLE;
      w_abort = r_state inside {S_GET_ADDR, S_READ_WAIT, S_READ_LOAD, S_READ_SHIFT,
                                S_WRITE_RECV, S_WRITE_COMMIT};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!cs_n) w_next = S_GET_ADDR;
        end
        S_GET_ADDR: begin
          w_cnt_en = sclk_rise;
          if (w_last_bit) w_next = S_GOT_ADDR;
        end
        S_GOT_ADDR: begin
          w_rd_next = sr_bit0;
          w_next    = sr_bit0 ? S_READ_WAIT : S_WRITE_RECV;
        end
        S_READ_WAIT: begin
          w_next = S_READ_LOAD;
        end
        S_READ_LOAD: begin
          w_next = S_READ_SHIFT;
        end
        S_READ_SHIFT: begin
          w_cnt_en = sclk_rise;
          if (w_last_bit) w_next = S_NEXT;
        end
        S_WRITE_RECV: begin
          w_cnt_en = sclk_rise;
          if (w_last_bit) w_next = S_WRITE_COMMIT;
        end
        S_WRITE_COMMIT: begin
          w_next = S_NEXT;
        end
        S_NEXT: begin
          // Burst continuation reuses the direction latched with the address byte.
          if (BURST_EN) w_next = r_rd ? S_READ_WAIT : S_WRITE_RECV;
          else          w_next = S_DONE;
        end
        S_DONE: begin
          w_next = S_DONE;
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end
  end

  // Bit counter restarts on every state change, so each byte starts from zero.
  always_comb begin
    w_bit_cnt_next = r_bit_cnt;
    if (w_next != r_state) begin
      w_bit_cnt_next = '0;
    end else if (w_cnt_en) begin
      w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_rd      <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_rd      <= w_rd_next;
    end
  end

  // Outputs are registered decodes of the state being entered, so each enable lines up with its state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_we    <= 1'b0;
      addr_we  <= 1'b0;
      addr_inc <= 1'b0;
      dm_we    <= 1'b0;
      miso_buf <= 1'b0;
      busy     <= 1'b0;
      abort    <= 1'b0;
    end else begin
      sr_we    <= (w_next == S_READ_LOAD);
      addr_we  <= (w_next == S_GOT_ADDR);
      addr_inc <= (w_next == S_NEXT) && BURST_EN;
      dm_we    <= (w_next == S_WRITE_COMMIT);
      miso_buf <= (w_next == S_READ_SHIFT);
      busy     <= (w_next != S_IDLE);
      abort    <= w_abort;
    end
  end

endmodule

// File: tb/tb_spi_txn_controller.sv
// Self-checking bench for spi_txn_controller: single-byte and burst instances share stimulus;
// pulse outputs are matched against a timed scoreboard, levels and pulse counts against a table.
module tb_spi_txn_controller;

  localparam int DATA_W = 8;
  localparam int K_ADDR = 0;
  localparam int K_SR   = 1;
  localparam int K_DM   = 2;
  localparam int K_INC  = 3;
  localparam int K_AB   = 4;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  typedef struct {
    string name;
    bit    rd;
    int    n;
    bit    simult;
    int    e0_addr;
    int    e0_sr;
    int    e0_dm;
    int    e0_ab;
    int    e1_inc;
    int    e1_sr;
  } vec_t;

  logic clk       = 1'b0;
  logic reset     = 1'b1;
  logic cs_n      = 1'b1;
  logic sclk_rise = 1'b0;
  logic sr_bit0   = 1'b0;

  logic s0_sr_we, s0_addr_we, s0_addr_inc, s0_dm_we, s0_miso_buf, s0_busy, s0_abort;
  logic s1_sr_we, s1_addr_we, s1_addr_inc, s1_dm_we, s1_miso_buf, s1_busy, s1_abort;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  q0[$];
  ev_t  q1[$];
  int   cnt0[5];
  int   cnt1[5];
  vec_t tbl[8];

  spi_txn_controller #(.DATA_W(DATA_W), .BURST_EN(1'b0)) u_single (
    .clk(clk), .reset(reset), .cs_n(cs_n), .sclk_rise(sclk_rise), .sr_bit0(sr_bit0),
    .sr_we(s0_sr_we), .addr_we(s0_addr_we), .addr_inc(s0_addr_inc), .dm_we(s0_dm_we),
    .miso_buf(s0_miso_buf), .busy(s0_busy), .abort(s0_abort)
  );

  spi_txn_controller #(.DATA_W(DATA_W), .BURST_EN(1'b1)) u_burst (
    .clk(clk), .reset(reset), .cs_n(cs_n), .sclk_rise(sclk_rise), .sr_bit0(sr_bit0),
    .sr_we(s1_sr_we), .addr_we(s1_addr_we), .addr_inc(s1_addr_inc), .dm_we(s1_dm_we),
    .miso_buf(s1_miso_buf), .busy(s1_busy), .abort(s1_abort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_ADDR:  return "addr_we";
      K_SR:    return "sr_we";
      K_DM:    return "dm_we";
      K_INC:   return "addr_inc";
      default: return "abort";
    endcase
  endfunction

  function automatic logic [31:0] out0();
    return 32'({s0_sr_we, s0_addr_we, s0_addr_inc, s0_dm_we, s0_miso_buf, s0_busy, s0_abort});
  endfunction

  function automatic logic [31:0] out1();
    return 32'({s1_sr_we, s1_addr_we, s1_addr_inc, s1_dm_we, s1_miso_buf, s1_busy, s1_abort});
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h, required %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input int d, input int k, input int c);
    ev_t ev;
    ev.kind = k;
    ev.cyc  = c;
    if (d == 0) q0.push_back(ev);
    else        q1.push_back(ev);
  endtask

  task automatic pop_ev(input int d, output bit ok, output ev_t ev);
    ok = 1'b0;
    ev = '{default: 0};
    if (d == 0) begin
      if (q0.size() > 0) begin ev = q0.pop_front(); ok = 1'b1; end
    end else begin
      if (q1.size() > 0) begin ev = q1.pop_front(); ok = 1'b1; end
    end
  endtask

  function automatic int front_cyc(input int d);
    if (d == 0) return (q0.size() > 0) ? q0[0].cyc : 32'h7fff_ffff;
    return (q1.size() > 0) ? q1[0].cyc : 32'h7fff_ffff;
  endfunction

  // Match every observed pulse against the oldest expected one; stale entries are misses.
  task automatic mon(input int d, input logic [4:0] p);
    ev_t ev;
    bit  ok;
    while (front_cyc(d) < cyc) begin
      pop_ev(d, ok, ev);
      checks++;
      errors++;
      $display("FAIL sb%0d_%s: no pulse at cyc %0d, required one", d, kname(ev.kind), ev.cyc);
    end
    for (int k = 0; k < 5; k++) begin
      if (p[k] === 1'b1) begin
        if (d == 0) cnt0[k]++;
        else        cnt1[k]++;
        pop_ev(d, ok, ev);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL sb%0d_%s: pulse at cyc %0d, required none", d, kname(k), cyc);
        end else if (ev.kind != k || ev.cyc != cyc) begin
          errors++;
          $display("FAIL sb%0d_%s: got %s at cyc %0d, required %s at cyc %0d",
                   d, kname(k), kname(k), cyc, kname(ev.kind), ev.cyc);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, {s0_abort, s0_addr_inc, s0_dm_we, s0_sr_we, s0_addr_we});
    mon(1, {s1_abort, s1_addr_inc, s1_dm_we, s1_sr_we, s1_addr_we});
  end

  // One sclk_rise every 8 clk; expected pulses are queued as the edge is driven.
  task automatic do_edge(input int k, input bit rd, input bit with_cs, input bit ab0, input bit ab1);
    int e;
    @(posedge clk);
    #1;
    sclk_rise = 1'b1;
    e = cyc + 1;
    if (with_cs) begin
      cs_n = 1'b1;
      if (ab0) push(0, K_AB, e);
      if (ab1) push(1, K_AB, e);
    end else if (k == DATA_W) begin
      push(0, K_ADDR, e);
      push(1, K_ADDR, e);
      if (rd) begin
        push(0, K_SR, e + 2);
        push(1, K_SR, e + 2);
      end
    end else if (k > DATA_W && (k % DATA_W) == 0) begin
      if (k == 2 * DATA_W && !rd) push(0, K_DM, e);
      if (rd) begin
        push(1, K_INC, e);
        push(1, K_SR, e + 2);
      end else begin
        push(1, K_DM, e);
        push(1, K_INC, e + 1);
      end
    end
    @(posedge clk);
    #1;
    sclk_rise = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    if (!with_cs)
      chk($sformatf("miso_buf_k%0d", k), 32'(s0_miso_buf),
          32'(rd && k >= DATA_W && k < 2 * DATA_W));
    repeat (3) @(posedge clk);
  endtask

  task automatic raise_cs(input bit ab0, input bit ab1);
    int e;
    @(posedge clk);
    #1;
    e = cyc + 1;
    if (ab0) push(0, K_AB, e);
    if (ab1) push(1, K_AB, e);
    cs_n = 1'b1;
  endtask

  task automatic run_txn(input vec_t v);
    int eff;
    eff = v.simult ? v.n - 1 : v.n;
    for (int i = 0; i < 5; i++) begin
      cnt0[i] = 0;
      cnt1[i] = 0;
    end
    @(posedge clk);
    #1;
    sr_bit0 = v.rd;
    cs_n    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({v.name, "_busy_start"}, 32'(s0_busy), 32'd1);
    for (int k = 1; k <= v.n; k++)
      do_edge(k, v.rd, v.simult && (k == v.n), eff < 2 * DATA_W, 1'b1);
    if (!v.simult) begin
      @(negedge clk);
      chk({v.name, "_busy_held"}, 32'(s0_busy), 32'd1);
      raise_cs(eff < 2 * DATA_W, 1'b1);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({v.name, "_busy0_end"}, 32'(s0_busy), 32'd0);
    chk({v.name, "_busy1_end"}, 32'(s1_busy), 32'd0);
    chk({v.name, "_n0_addr_we"}, cnt0[K_ADDR], v.e0_addr);
    chk({v.name, "_n0_sr_we"},   cnt0[K_SR],   v.e0_sr);
    chk({v.name, "_n0_dm_we"},   cnt0[K_DM],   v.e0_dm);
    chk({v.name, "_n0_abort"},   cnt0[K_AB],   v.e0_ab);
    chk({v.name, "_n1_addr_inc"}, cnt1[K_INC], v.e1_inc);
    chk({v.name, "_n1_sr_we"},   cnt1[K_SR],   v.e1_sr);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    //          name                 rd  n  sim a0 s0 d0 ab0 inc1 sr1
    tbl[0] = '{"write",              0, 16, 0, 1, 0, 1, 0,  1,   0};
    tbl[1] = '{"read",               1, 16, 0, 1, 1, 0, 0,  1,   2};
    tbl[2] = '{"burst_read",         1, 24, 0, 1, 1, 0, 0,  2,   3};
    tbl[3] = '{"addr_abort",         0,  4, 0, 0, 0, 0, 1,  0,   0};
    tbl[4] = '{"write_after_abort",  0, 16, 0, 1, 0, 1, 0,  1,   0};
    tbl[5] = '{"simult_abort",       0, 16, 1, 1, 0, 0, 1,  0,   0};
    tbl[6] = '{"burst_write",        0, 32, 0, 1, 0, 1, 0,  3,   0};
    tbl[7] = '{"read_abort",         1, 12, 0, 1, 1, 0, 1,  0,   1};

    @(negedge clk);
    chk("reset_out0", out0(), 32'd0);
    chk("reset_out1", out1(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_out0", out0(), 32'd0);
    chk("idle_out1", out1(), 32'd0);

    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    // Reset in the middle of a write data byte: outputs clear at once, no abort or dm_we.
    @(posedge clk);
    #1;
    sr_bit0 = 1'b0;
    cs_n    = 1'b0;
    repeat (2) @(posedge clk);
    for (int k = 1; k <= DATA_W + 3; k++) do_edge(k, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_pre_busy", 32'(s0_busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_out0", out0(), 32'd0);
    chk("rst_async_out1", out1(), 32'd0);
    @(posedge clk);
    #1;
    cs_n = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_release_out0", out0(), 32'd0);
    chk("rst_release_out1", out1(), 32'd0);

    run_txn(tbl[0]);

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("sb0_drained", 32'(q0.size()), 32'd0);
    chk("sb1_drained", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
